// File: rtl/execute_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : execute_pipe
//  Description : Registered, handshaked execute stage. Selects operand B
//                (register or immediate), evaluates single-cycle ALU ops,
//                runs an iterative shift-add multiply, and holds the result,
//                compare flags and destination register until consumed.
//  Revision    : 1.0  initial release
// ============================================================================
module execute_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] RD1,
    input  logic [DATA_WIDTH-1:0] RD2,
    input  logic [DATA_WIDTH-1:0] Imm_o,
    input  logic                  ALUsrc,
    input  logic [3:0]            ALUctrl,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALU_o,
    output logic                  EQ,
    output logic                  LT,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  busy
);

    localparam int c_SHAMT_W = $clog2(DATA_WIDTH);
    localparam int c_CNT_W   = c_SHAMT_W + 1;

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_SLT  = 4'd5;
    localparam logic [3:0] c_OP_SLTU = 4'd6;
    localparam logic [3:0] c_OP_SLL  = 4'd7;
    localparam logic [3:0] c_OP_SRL  = 4'd8;
    localparam logic [3:0] c_OP_SRA  = 4'd9;
    localparam logic [3:0] c_OP_MUL  = 4'd10;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [c_CNT_W-1:0]    r_cnt;

    logic [DATA_WIDTH-1:0] w_opb;
    logic [c_SHAMT_W-1:0]  w_shamt;
    logic [DATA_WIDTH-1:0] w_alu;
    logic [DATA_WIDTH-1:0] w_acc_step;
    logic                  w_accept;
    logic                  w_is_mul;
    logic                  w_mul_start;
    logic                  w_mul_last;

    assign w_opb       = ALUsrc ? Imm_o : RD2;
    assign w_shamt     = w_opb[c_SHAMT_W-1:0];
    assign in_ready    = (r_state == S_IDLE) && (!out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_is_mul    = (ALUctrl == c_OP_MUL);
    assign w_mul_start = w_accept && w_is_mul;
    assign w_mul_last  = (r_state == S_MUL) && (r_cnt == c_CNT_W'(1));
    assign w_acc_step  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign busy        = (r_state == S_MUL);

    // Single-cycle ALU result; MUL and reserved codes yield zero here
    always_comb begin
        w_alu = '0;
        case (ALUctrl)
            c_OP_ADD:  w_alu = RD1 + w_opb;
            c_OP_SUB:  w_alu = RD1 - w_opb;
            c_OP_AND:  w_alu = RD1 & w_opb;
            c_OP_OR:   w_alu = RD1 | w_opb;
            c_OP_XOR:  w_alu = RD1 ^ w_opb;
            c_OP_SLT:  w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(RD1) < $signed(w_opb))};
            c_OP_SLTU: w_alu = {{(DATA_WIDTH-1){1'b0}}, (RD1 < w_opb)};
            c_OP_SLL:  w_alu = RD1 << w_shamt;
            c_OP_SRL:  w_alu = RD1 >> w_shamt;
            c_OP_SRA:  w_alu = $unsigned($signed(RD1) >>> w_shamt);
            default:   w_alu = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: enter MUL on a multiply accept, leave on the final step
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_mul_start) w_state_nxt = S_MUL;
            S_MUL:   if (w_mul_last)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Iterative shift-add multiplier: one multiplier bit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_mul_start) begin
                r_mcand  <= RD1;
                r_mplier <= w_opb;
                r_acc    <= '0;
                r_cnt    <= c_CNT_W'(DATA_WIDTH);
            end
        end else begin
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - c_CNT_W'(1);
        end
    end

    // Output slot: load on completion, otherwise drain when consumed.
    // Flags and destination are taken at accept even for MUL; the slot is
    // empty (or being emptied) at that moment, so nothing valid is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ALU_o     <= '0;
            EQ        <= 1'b0;
            LT        <= 1'b0;
            rd_out    <= '0;
        end else if (w_mul_last) begin
            out_valid <= 1'b1;
            ALU_o     <= w_acc_step;
        end else if (w_accept) begin
            EQ     <= (RD1 == w_opb);
            LT     <= ($signed(RD1) < $signed(w_opb));
            rd_out <= rd_in;
            if (w_is_mul) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= 1'b1;
                ALU_o     <= w_alu;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/execute_pipe.md
# execute_pipe

Registered, handshaked execute stage for the pipelined core. Selects the second operand (register or immediate), performs single-cycle ALU operations, and runs a multi-cycle iterative multiply. It holds the result, branch-compare flags and destination register in an output register until the memory stage accepts them. It sits between the decode/register-file stage and the memory stage, and supplies back-pressure in both directions.

## Interface
- DATA_WIDTH, 32, operand/result width; power of two, ≥8
- REG_ADDR_W, 5, destination register index width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream presents an operation
- in_ready  out  1  stage accepts an operation this cycle
- RD1  in  DATA_WIDTH  operand A
- RD2  in  DATA_WIDTH  register operand B
- Imm_o  in  DATA_WIDTH  immediate operand B
- ALUsrc  in  1  1 selects Imm_o as operand B, 0 selects RD2
- ALUctrl  in  4  operation code; see Operation
- rd_in  in  REG_ADDR_W  destination register, passed through
- out_valid  out  1  output register holds a result
- out_ready  in  1  downstream consumes the result
- ALU_o  out  DATA_WIDTH  result
- EQ  out  1  A == B, captured at accept
- LT  out  1  signed A < B, captured at accept
- rd_out  out  REG_ADDR_W  destination register of the result
- busy  out  1  multiply in progress

## Operation
- Operand B = ALUsrc ? Imm_o : RD2. A transfer occurs when in_valid && in_ready.
- ALUctrl: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL (low DATA_WIDTH bits of the product), 11–15 reserved (result 0, no error).
- Arithmetic wraps modulo 2^DATA_WIDTH. SLT/SLTU return 0 or 1, zero-extended. The shift amount is B[log2(DATA_WIDTH)-1:0]; upper bits of B are ignored.
- EQ, LT and rd_in are captured at accept for every opcode, including MUL.
- FSM states:
  - IDLE → IDLE on a non-MUL accept; the result is written to the output register at that same edge.
  - IDLE → MUL on a MUL accept. The multiplicand, multiplier and accumulator are loaded, and the counter is set to DATA_WIDTH.
  - MUL: each cycle, add the multiplicand to the accumulator if multiplier[0] is 1, shift the multiplicand left, shift the multiplier right, and decrement the counter. When the counter reaches 1, the final accumulator is written to the output register, out_valid is set, and the FSM returns to IDLE.
- in_ready = (state == IDLE) && (!out_valid || out_ready). This is a combinational path from out_ready.
- Output register: loads on a completing operation. Otherwise, out_valid clears when out_ready is high, and all outputs hold while out_valid && !out_ready.
- busy = (state == MUL).
- An accept and a consume in the same cycle are legal: the new result replaces the old one and out_valid stays 1.

## Timing
- Reset (asynchronous assert, synchronous-safe release) values: state IDLE, out_valid 0, ALU_o 0, EQ 0, LT 0, rd_out 0, busy 0, internal multiply registers 0.
- Non-MUL latency is 1: accept at edge N, out_valid is high after edge N. Throughput is one operation per cycle when out_ready is held at 1.
- MUL latency is DATA_WIDTH: accept at edge N, out_valid is high after edge N+DATA_WIDTH. in_ready is 0 from after edge N until completion.
- Reset during MUL aborts the multiply. No result is produced, and in_ready is 1 in the first cycle after release.
- The output slot is always empty when a MUL completes, because acceptance required a free or freeing slot and no other operation can enter.
- Input fields are sampled only on accept; changes on non-accept cycles have no effect.

## Test plan
- ADD with ALUsrc=1, RD1=5, Imm_o=0xFFFFFFFF, rd_in=3, out_ready=1 → next cycle ALU_o=4, EQ=0, LT=0, rd_out=3, out_valid=1.
- Back-pressure: SUB 10−10 accepted with out_ready=0 → ALU_o=0, EQ=1, out_valid=1 held for 5 cycles, in_ready=0 throughout. Raising out_ready gives a same-cycle accept of the next op.
- MUL 7×6 (ALUctrl=10) → busy=1 and in_ready=0 for 32 cycles, then ALU_o=42 with out_valid after edge N+32. 0xFFFFFFFF×0xFFFFFFFF → ALU_o=1.
- SRA 0x80000000 by B=0x21 → ALU_o=0xC0000000 (shift 1). SLTU 1 vs 0xFFFFFFFF → 1, LT=0.
- Back-to-back stream of 8 ADDs with out_ready=1 → 8 results on consecutive cycles, no bubbles, rd_out in order.
- Assert rst_n low on cycle 10 of a MUL → all outputs return to reset values immediately. After release there is no stale out_valid, and a following ADD completes normally. Reserved op 13 → ALU_o=0.
